// File: rtl/mult_dot_seq.sv
// -----------------------------------------------------------------------------
// mult_dot_seq
//   Sequencer wrapped around a 4x4 multiplier. It takes operand pairs on a
//   valid/ready input and issues one multiply per pair. The operands stay
//   registered and stable for the whole multiply. Each product is captured on
//   process_done and added into a running dot product. After LEN products the
//   sum is offered on a valid/ready output. A watchdog ends a multiply that
//   never completes and flags the result as aborted.
//
// Parameters
//   LEN     products accumulated per result (>= 1)
//   ACC_W   accumulator / result width (>= 8)
//   TO_CYC  largest wdog value reached in S_WAIT before the multiply is abandoned
//
// Ports
//   CLK, RESETn              clock; synchronous active-low reset
//   in_valid/in_ready        operand handshake, ready only in S_IDLE
//   in_a, in_b               operands latched on acceptance
//   process_start            one-cycle start pulse to the multiplier
//   multiplier, multiplicand registered operands driven to the multiplier
//   product, process_done    multiplier result and its one-cycle strobe
//   out_valid/out_ready      result handshake
//   out_sum                  accumulated (wrapped) sum
//   out_ovf                  carry out of the accumulator seen in this result
//   out_err                  result ended by the watchdog (partial sum)
// -----------------------------------------------------------------------------
module mult_dot_seq #(
  parameter int LEN    = 4,
  parameter int ACC_W  = 12,
  parameter int TO_CYC = 31
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             process_start,
  output logic [3:0]       multiplier,
  output logic [3:0]       multiplicand,
  input  logic [7:0]       product,
  input  logic             process_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int IDX_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int WD_W  = $clog2(TO_CYC + 1);
  localparam int SUM_W = ACC_W + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEN - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TO_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [3:0]       mplr_q, mplr_d;
  logic [3:0]       mcand_q, mcand_d;
  logic             out_valid_q, out_valid_d;

  // One extra bit catches the carry out of the accumulator.
  logic [SUM_W-1:0] sum_ext;
  assign sum_ext = {1'b0, acc_q} + SUM_W'(product);

  always_comb begin
    // NOTE: every *_d takes its held value first. A path through the case that
    // does not assign a signal then keeps the value, and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    wdog_d  = wdog_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;

    case (state_q)
      S_IDLE: begin
        // Operands change only here. The multiplier re-reads them in all
        // of its busy states.
        if (in_valid) begin
          mplr_d  = in_a;
          mcand_d = in_b;
          state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // A completion in the watchdog's final cycle still counts.
        if (process_done) begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
          if (idx_q == IDX_LAST) begin
            state_d = S_OUT;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_IDLE;
          end
        end else if (wdog_q == WD_LIMIT) begin
          err_d   = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    out_valid_d = (state_d == S_OUT);
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together from values taken before the edge. The reset covers
  // every register because the design holds no memory array.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      wdog_q      <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      mplr_q      <= '0;
      mcand_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      wdog_q      <= wdog_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      mplr_q      <= mplr_d;
      mcand_q     <= mcand_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign process_start = (state_q == S_START);
  assign multiplier    = mplr_q;
  assign multiplicand  = mcand_q;
  assign out_valid     = out_valid_q;
  assign out_sum       = acc_q;
  assign out_ovf       = ovf_q;
  assign out_err       = err_q;

endmodule
